// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that time-shares one external 32-bit adder among NREQ requesters.
// Optional signed-overflow result (rsp_ovf) is enabled with `define ADDER_ARB_OVF_EN.
module adder_rr_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int IDW   = 2,
  localparam int NREQ  = 2**IDW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_carry,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_carry
`ifdef ADDER_ARB_OVF_EN
 ,output logic                    rsp_ovf
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                      state_q;
  logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]              id_q;
  logic [NREQ-1:0]             gnt_q;
  logic [WIDTH-1:0]            op_a_q, op_b_q;
  logic                        op_cin_q;
  logic                        rsp_valid_q, rsp_carry_q;
  logic [IDW-1:0]              rsp_id_q;
  logic [WIDTH-1:0]            rsp_sum_q;

  logic [NREQ-1:0][WIDTH-1:0]  opa_v, opb_v;
  logic                        win_vld;
  logic [IDW-1:0]              win_id, idx;

  assign opa_v = req_a;
  assign opb_v = req_b;

  // Scan from rr_ptr upward; descending loop so the closest set bit wins last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = rr_ptr_q + IDW'(k);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign rr_ptr_d = win_id + 1'b1;

`ifdef ADDER_ARB_OVF_EN
  logic ovf_d, rsp_ovf_q;
  assign ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (add_sum[WIDTH-1] != op_a_q[WIDTH-1]);
  assign rsp_ovf = rsp_ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            op_a_q   <= opa_v[win_id];
            op_b_q   <= opb_v[win_id];
            op_cin_q <= req_cin[win_id];
            id_q     <= win_id;
            gnt_q    <= NREQ'(1) << win_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          // Operands have been stable on add_* for a full cycle; take the result.
          gnt_q       <= '0;
          rsp_sum_q   <= add_sum;
          rsp_carry_q <= add_carry;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
`ifdef ADDER_ARB_OVF_EN
          rsp_ovf_q   <= ovf_d;
`endif
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign add_cin   = op_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: grants and responses are checked in order
// against expectations queued when requests are driven.
module tb_adder_rr_arbiter;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;
  localparam int NREQ  = 4;

  logic                  clk, rst_n;
  logic [NREQ-1:0]       req, req_cin, gnt;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      add_a, add_b, add_sum, rsp_sum;
  logic                  add_cin, add_carry, rsp_valid, rsp_ready, rsp_carry;
  logic [IDW-1:0]        rsp_id;
`ifdef ADDER_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  typedef struct {
    int              id;
    logic [WIDTH-1:0] sum;
    logic            carry;
    logic            ovf;
  } exp_t;

  int   gq[$];
  exp_t rq[$];
  logic [WIDTH-1:0] ta [NREQ];
  logic [WIDTH-1:0] tbv[NREQ];
  logic             tc [NREQ];
  int   n_chk = 0;
  int   n_fail = 0;

  adder_rr_arbiter #(.WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
`ifdef ADDER_ARB_OVF_EN
   ,.rsp_ovf(rsp_ovf)
`endif
  );

  // External adder
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c);
    ta[i] = a; tbv[i] = b; tc[i] = c;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i] = c;
  endtask

  task automatic push_gnt(input int id);
    gq.push_back(id);
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    logic [WIDTH:0] s;
    s = {1'b0, ta[id]} + {1'b0, tbv[id]} + (WIDTH+1)'(tc[id]);
    e.id = id; e.sum = s[WIDTH-1:0]; e.carry = s[WIDTH];
    e.ovf = (ta[id][WIDTH-1] == tbv[id][WIDTH-1]) && (s[WIDTH-1] != ta[id][WIDTH-1]);
    gq.push_back(id);
    rq.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (gnt != '0) begin
      if (gq.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'd0);
      else begin
        int id;
        id = gq.pop_front();
        chk("gnt_order", 64'(gnt), 64'(1) << id);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (rq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        exp_t e;
        e = rq.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
        chk("rsp_carry", 64'(rsp_carry), 64'(e.carry));
`ifdef ADDER_ARB_OVF_EN
        chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnts(input int k);
    int c = 0;
    int t = 0;
    while (c < k && t < 50) begin
      @(negedge clk); t++;
      if (gnt != '0) c++;
    end
    if (c < k) chk("gnt_timeout", 64'(c), 64'(k));
  endtask

  task automatic drain();
    int t = 0;
    while ((gq.size() != 0 || rq.size() != 0) && t < 100) begin
      @(negedge clk); t++;
    end
    chk("drain_left", 64'(gq.size() + rq.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic single(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c);
    tick();
    set_op(id, a, b, c);
    push_exp(id);
    req = NREQ'(1) << id;
    wait_gnts(1);
    req = '0;
    drain();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_add_a"}, 64'(add_a), 64'd0);
    chk({tag, "_add_b"}, 64'(add_b), 64'd0);
    chk({tag, "_add_cin"}, 64'(add_cin), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_sum"}, 64'(rsp_sum), 64'd0);
    chk({tag, "_rsp_carry"}, 64'(rsp_carry), 64'd0);
  endtask

  initial begin
    exp_t hold;
    logic [WIDTH:0] s;
    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin ta[i] = '0; tbv[i] = '0; tc[i] = 1'b0; end
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request with explicit latency
    tick();
    set_op(0, 32'd500, 32'd600, 1'b0);
    push_exp(0);
    req = 4'b0001;
    @(negedge clk);
    chk("gnt_before_sample", 64'(gnt), 64'd0);
    @(negedge clk);
    chk("gnt_lat", 64'(gnt), 64'b0001);
    chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
    chk("add_a_issue", 64'(add_a), 64'd500);
    req = '0;
    @(negedge clk);
    chk("rsp_valid_lat", 64'(rsp_valid), 64'd1);
    chk("gnt_pulse", 64'(gnt), 64'd0);
    drain();
    chk("rsp_valid_fall", 64'(rsp_valid), 64'd0);
    chk("rsp_sum_retained", 64'(rsp_sum), 64'd1100);

    // Carry / wrap
    single(2, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("wrap_sum_retained", 64'(rsp_sum), 64'd1);
    // Move pointer to 0 for the fairness sweep
    single(3, 32'd7, 32'd9, 1'b0);

    // Fairness: all requesting continuously
    tick();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(1000 * (i + 1)), 32'(i * 7 + 3), 1'(i & 1));
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    req = 4'b1111;
    wait_gnts(5);
    req = '0;
    drain();

    // Pointer to 3, then 1001 -> 3 then 0
    single(2, 32'd40, 32'd2, 1'b0);
    tick();
    push_exp(3); push_exp(0);
    req = 4'b1001;
    wait_gnts(2);
    req = '0;
    drain();

    // Backpressure with other requests pending; pointer is now 1
    tick();
    rsp_ready = 1'b0;
    set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    push_exp(1);
    hold = rq[rq.size()-1];
    req = 4'b0010;
    wait_gnts(1);
    req = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_sum", 64'(rsp_sum), 64'(hold.sum));
      chk("bp_id", 64'(rsp_id), 64'd1);
      chk("bp_no_gnt", 64'(gnt), 64'd0);
    end
    chk("bp_sum_const", 64'(hold.sum), 64'h2345_678A);
    push_exp(2); push_exp(0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_reentry", 64'(gnt), 64'd0);
    wait_gnts(2);
    req = '0;
    drain();

    // Reset while in RESP; pointer is now 1
    tick();
    rsp_ready = 1'b0;
    set_op(1, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1);
    push_gnt(1);
    req = 4'b0010;
    wait_gnts(1);
    req = '0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(50 + i), 32'(5 * i), 1'b0);
    push_exp(0);
    req = 4'b1111;
    wait_gnts(1);
    req = '0;
    drain();

    // Signed overflow cases (sum/carry checked in every build)
    single(1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    chk("ovf_case_sum", 64'(rsp_sum), 64'h8000_0000);
    single(2, 32'd1500, 32'd11600, 1'b1);
    chk("nonovf_case_sum", 64'(rsp_sum), 64'd13101);
    s = {1'b0, 32'h7FFF_FFFF} + 33'd1;
    chk("bench_model_sanity", 64'(s), 64'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one 32-bit combinational ripple adder (a, b, cin -> sum, carry) among NREQ requesters.
- Round-robin arbitration, registered operand issue, and a valid/ready result return tagged with the requester ID.
- Sits between client blocks and the single adder instance; the adder is external and connected through the add_* ports.

Parameters:
- WIDTH, 32, operand/sum width.
- IDW, 2, requester ID width; NREQ = 2**IDW (default 4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request, level; held until that requester's gnt.
- req_a  in  NREQ*WIDTH  flattened operand A; slice i = requester i.
- req_b  in  NREQ*WIDTH  flattened operand B.
- req_cin  in  NREQ  per-requester carry-in.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester were captured.
- add_a  out  WIDTH  to adder a.
- add_b  out  WIDTH  to adder b.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder sum.
- add_carry  in  1  from adder carry.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  requester ID owning the result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_carry  out  1  registered carry-out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, and the following outputs are 0: gnt, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_carry.
- add_a/add_b/add_cin are driven directly from the internal operand registers. They change only on capture.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req != 0, select the winner by round-robin: first set bit scanning from index rr_ptr upward, wrapping modulo NREQ.
  - On that edge: capture the winner's req_a/req_b/req_cin into the operand registers, capture the ID, set the winner's gnt bit for exactly the next cycle, set rr_ptr = winner+1 (mod NREQ), go to EXEC.
  - If req == 0, stay in IDLE; no register changes.
- EXEC (one cycle, gnt pulse visible here):
  - On the edge: capture add_sum/add_carry into rsp_sum/rsp_carry, latched ID to rsp_id, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_sum/rsp_carry held stable.
  - If rsp_ready=1: clear rsp_valid on the edge and go to IDLE.
  - If rsp_ready=0: hold indefinitely.
  - rsp_* retain their last values after rsp_valid falls.
- Latency: req sampled in cycle N -> gnt high in N+1 -> rsp_valid high from N+2. Minimum 3 cycles per transaction.
- rsp_ready while rsp_valid=0: ignored.
- req asserted or dropped outside IDLE: ignored; only IDLE sampling matters. A requester dropping req before gnt is simply not served.
- A requester may re-assert req in the cycle after its gnt. It is eligible at the next IDLE but has lowest priority.
- Sum arithmetic is the adder's: WIDTH-bit wrap-around, with carry = bit WIDTH of a+b+cin.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no gnt or rsp replay, and all state returns to reset values.

Optional Feature:
- Macro: ADDER_ARB_OVF_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), registered in EXEC alongside rsp_sum.
  - rsp_ovf = signed overflow = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]).
  - Held with the other rsp_* outputs; reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Single request: req=0001, a0=500, b0=600, cin0=0 -> gnt=0001 for one cycle, rsp_valid 2 cycles after sampling, rsp_id=0, rsp_sum=1100, rsp_carry=0.
- Carry/wrap: requester 2, a=32'hFFFFFFFF, b=1, cin=1 -> rsp_id=2, rsp_sum=1, rsp_carry=1.
- Fairness with rsp_ready tied 1:
  - req=1111 held continuously -> grant order 0,1,2,3,0.
  - Next, req=1001 with rr_ptr=3 -> 3 then 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP with requests pending -> rsp_* stable, no new gnt. Release -> next grant follows IDLE re-entry.
- Reset mid-RESP: rst_n low for 1 cycle while rsp_valid=1 -> all outputs 0 immediately (asynchronous). Afterwards, req=1111 -> first grant is requester 0.
- With ADDER_ARB_OVF_EN: a=32'h7FFFFFFF, b=1, cin=0 -> rsp_sum=32'h80000000, rsp_carry=0, rsp_ovf=1. Case 1500+11600+1 -> 13101, rsp_ovf=0.
